// File: rtl/a2d_pkg.sv
// Shared types and constants for the IR-sensor A2D SPI master.
package a2d_pkg;

   // Master is either waiting for a start request or running a frame.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // One SPI frame is 16 bits; the A2D returns its result in the last 12.
   localparam int A2D_FRAME_BITS = 16;
   localparam int A2D_RES_BITS   = 12;

   // Channel address field inside the outgoing frame word.
   localparam int ADDR_BITS = 3;
   localparam int ADDR_LSB  = 11;
   localparam int ADDR_MSB  = 13;

   // Bit counter: counts falling SCLK edges, the first one is a dummy edge.
   localparam int             BIT_CNT_W    = 5;
   localparam logic [4:0]     BIT_CNT_LAST = 5'd16;

   // Divider preload for the default 5-bit divider: SCLK starts high and
   // falls after 9 clocks, giving a short front porch after SS_n drops.
   localparam logic [4:0]     SCLK_PRELOAD = 5'b10111;

endpackage : a2d_pkg

// File: rtl/a2d_sclk_div.sv
// SCLK generator: free-running divider while a frame is active, with the
// sample (just before SCLK rises) and shift (just before SCLK falls) strobes.
module a2d_sclk_div
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_sclk,
   output logic o_smpl,
   output logic o_shft
);

   // Preload keeps the top two bits of the default pattern and fills the
   // rest with ones so the front porch scales with the divider width.
   localparam logic [SCLK_DIV_W-1:0] LP_PRELOAD =
      {SCLK_PRELOAD[4:3], {(SCLK_DIV_W-2){1'b1}}};
   // Divider value one clock before the MSB (SCLK) goes high.
   localparam logic [SCLK_DIV_W-1:0] LP_SMPL =
      {1'b0, {(SCLK_DIV_W-1){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] LP_ONE =
      {{(SCLK_DIV_W-1){1'b0}}, 1'b1};

   logic [SCLK_DIV_W-1:0] r_sclk_div;

   // Divider: preloaded on frame start, counts every clock during the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_div <= '0;
      end else if (i_load) begin
         r_sclk_div <= LP_PRELOAD;
      end else if (i_en) begin
         r_sclk_div <= r_sclk_div + LP_ONE;
      end
   end

   // SCLK idles high (mode 3); strobes only exist while a frame runs.
   assign o_sclk = i_en ? r_sclk_div[SCLK_DIV_W-1] : 1'b1;
   assign o_smpl = i_en & (r_sclk_div == LP_SMPL);
   assign o_shft = i_en & (&r_sclk_div);

endmodule : a2d_sclk_div

// File: rtl/a2d_intf.sv
// SPI master for the 8-channel 12-bit IR-sensor A2D. A start request sends
// the channel address in one 16-bit frame and returns the 12-bit result
// with a sticky completion flag.
//
// Start handshake: strt_cnv acts as a one-clock valid; the block is ready
// only in IDLE. A strt_cnv seen in IDLE is accepted on that edge (chnnl is
// captured, cnv_cmplt clears); a strt_cnv seen while a frame runs, including
// the frame's final clock, is dropped and must be reissued.
module a2d_intf
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    strt_cnv,
   input  logic [ADDR_BITS-1:0]    chnnl,
   output logic                    cnv_cmplt,
   output logic [A2D_RES_BITS-1:0] res,
   output logic                    SS_n,
   output logic                    SCLK,
   output logic                    MOSI,
   input  logic                    MISO
);

   state_t                      r_state;
   logic [BIT_CNT_W-1:0]        r_bit_cnt;
   logic [A2D_FRAME_BITS-1:0]   r_shft_reg;
   logic                        r_miso_smpl;
   logic                        r_ss_n;
   logic                        r_cnv_cmplt;
   logic [A2D_RES_BITS-1:0]     r_res;

   logic                        w_load;
   logic                        w_en;
   logic                        w_smpl;
   logic                        w_shft;
   logic                        w_last;
   logic                        w_sclk;
   logic [A2D_FRAME_BITS-1:0]   w_load_word;

   assign w_load = (r_state == IDLE) & strt_cnv;
   assign w_en   = (r_state == SHIFT);
   // The 16th real falling edge would be the 17th fall: end the frame there
   // instead, so SCLK stays high and the last MISO sample goes straight to res.
   assign w_last = w_shft & (r_bit_cnt == BIT_CNT_LAST);

   a2d_sclk_div #(
      .SCLK_DIV_W (SCLK_DIV_W)
   ) u_sclk_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (w_en),
      .o_sclk (w_sclk),
      .o_smpl (w_smpl),
      .o_shft (w_shft)
   );

   // Outgoing frame word: zeros except the channel address field.
   always_comb begin
      w_load_word = '0;
      w_load_word[ADDR_MSB:ADDR_LSB] = chnnl;
   end

   // Frame sequencer: start capture, MISO sampling, shifting and result update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_shft_reg  <= '0;
         r_miso_smpl <= 1'b0;
         r_ss_n      <= 1'b1;
         r_cnv_cmplt <= 1'b0;
         r_res       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (strt_cnv) begin
                  r_state     <= SHIFT;
                  r_ss_n      <= 1'b0;
                  r_cnv_cmplt <= 1'b0;
                  r_bit_cnt   <= '0;
                  r_shft_reg  <= w_load_word;
               end
            end
            SHIFT: begin
               if (w_smpl) begin
                  r_miso_smpl <= MISO;
               end
               if (w_shft) begin
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  // The first falling edge only starts the clock; the A2D
                  // has not shifted anything out yet, so nothing moves.
                  if (r_bit_cnt != '0) begin
                     r_shft_reg <= {r_shft_reg[A2D_FRAME_BITS-2:0], r_miso_smpl};
                  end
               end
               if (w_last) begin
                  r_state     <= IDLE;
                  r_ss_n      <= 1'b1;
                  r_cnv_cmplt <= 1'b1;
                  r_res       <= {r_shft_reg[A2D_RES_BITS-2:0], r_miso_smpl};
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign SS_n      = r_ss_n;
   assign SCLK      = w_sclk;
   assign MOSI      = r_shft_reg[A2D_FRAME_BITS-1];
   assign cnv_cmplt = r_cnv_cmplt;
   assign res       = r_res;

   // Slave select is low exactly while a frame is running.
   a_ss_matches_state : assert property (
      @(posedge clk) disable iff (!rst_n) (r_state == SHIFT) == !r_ss_n);

   // A running frame never counts past the final edge.
   a_bit_cnt_range : assert property (
      @(posedge clk) disable iff (!rst_n) (r_state == SHIFT) |-> (r_bit_cnt <= BIT_CNT_LAST));

endmodule : a2d_intf

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: SPI slave model of the A2D, cycle-level reference model
// of the frame timing, and directed plus randomized frames.
module tb_a2d_intf;

   logic        clk;
   logic        rst_n;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   int          n_checks;
   int          n_errs;

   // A2D conversion values per channel.
   logic [11:0] tbl [8];
   // Expected 16-bit MOSI word of each accepted frame.
   logic [15:0] exp_q [$];

   // Reference model state: a frame is "age" edges old, edge 1 = accept.
   bit          m_busy;
   int          m_age;
   logic        m_cnv;
   logic [11:0] m_res;
   logic [11:0] m_frame_val;

   // Slave capture.
   int          rise_cnt;
   logic [15:0] rx;

   a2d_intf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after the falling edge, away from both sample points.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // SCLK expected from frame age: 9 clk high, then 16 low / 16 high.
   function automatic logic exp_sclk(input bit busy, input int age);
      if (!busy || age < 10) return 1'b1;
      return (((age - 10) / 16) % 2) == 1;
   endfunction

   // Reference model: frame occupies edges 1..521 after accept, done at 522.
   initial begin
      m_busy = 0; m_age = 0; m_cnv = 1'b0; m_res = '0; m_frame_val = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_age = 0; m_cnv = 1'b0; m_res = '0;
         end else if (m_busy) begin
            m_age++;
            if (m_age == 522) begin
               m_busy = 0;
               m_cnv  = 1'b1;
               m_res  = m_frame_val;
            end
         end else if (strt_cnv) begin
            m_busy      = 1;
            m_age       = 1;
            m_cnv       = 1'b0;
            m_frame_val = tbl[chnnl];
            exp_q.push_back({2'b00, chnnl, 11'h000});
         end
      end
   end

   // A2D slave: captures MOSI on SCLK rises, drives MISO on SCLK falls.
   // Rises 1..4 carry junk; rises 5..16 carry the 12-bit value MSB first.
   initial begin
      logic p_ss;
      logic p_sclk;
      int   k;
      MISO = 1'b0; rise_cnt = 0; rx = '0; p_ss = 1'b1; p_sclk = 1'b1;
      forever begin
         @(SS_n or SCLK);
         if (p_ss === 1'b1 && SS_n === 1'b0) begin
            rise_cnt = 0;
            rx       = '0;
         end
         if (SS_n === 1'b0 && p_sclk === 1'b0 && SCLK === 1'b1) begin
            rx = {rx[14:0], MOSI};
            rise_cnt++;
         end
         if (SS_n === 1'b0 && p_sclk === 1'b1 && SCLK === 1'b0) begin
            k = rise_cnt + 1;
            if (k >= 5 && k <= 16) MISO = m_frame_val[16 - k];
            else                   MISO = 1'($urandom_range(0, 1));
         end
         p_ss   = SS_n;
         p_sclk = SCLK;
      end
   end

   // Every-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("ss_n", {31'd0, SS_n}, {31'd0, !m_busy});
         check("sclk", {31'd0, SCLK}, {31'd0, exp_sclk(m_busy, m_age)});
         check("cnv_cmplt", {31'd0, cnv_cmplt}, {31'd0, m_cnv});
         check("res", {20'd0, res}, {20'd0, m_res});
         if (!rst_n) check("mosi_rst", {31'd0, MOSI}, 32'd0);
      end
   end

   task automatic start(input logic [2:0] ch);
      tick();
      strt_cnv = 1'b1;
      chnnl    = ch;
      tick();
      strt_cnv = 1'b0;
   endtask

   // Bounded wait for completion; returns the position n it was seen at.
   task automatic wait_done(input bit scramble, output int n_out);
      int n;
      n = 1;
      while (cnv_cmplt !== 1'b1 && n < 600) begin
         tick();
         n++;
         if (scramble) chnnl = 3'($urandom_range(0, 7));
      end
      n_out = n;
   endtask

   task automatic frame_checks(input logic [2:0] ch);
      check("rises", rise_cnt, 16);
      if (exp_q.size() == 0) check("exp_q_size", 0, 1);
      else                   check("mosi_word", {16'd0, rx}, {16'd0, exp_q.pop_front()});
      check("res_tbl", {20'd0, res}, {20'd0, tbl[ch]});
   endtask

   task automatic do_frame(input logic [2:0] ch, input bit scramble);
      int n;
      start(ch);
      wait_done(scramble, n);
      check("done_cycle", n, 522);
      frame_checks(ch);
   endtask

   initial begin
      n_checks = 0; n_errs = 0;
      rst_n = 1'b0; strt_cnv = 1'b0; chnnl = 3'd0;
      for (int i = 0; i < 8; i++) tbl[i] = 12'(i * 12'h111);

      // Reset values
      repeat (3) tick();
      check("rst_ss_n", {31'd0, SS_n}, 32'd1);
      check("rst_sclk", {31'd0, SCLK}, 32'd1);
      check("rst_cnv", {31'd0, cnv_cmplt}, 32'd0);
      check("rst_res", {20'd0, res}, 32'd0);
      check("rst_mosi", {31'd0, MOSI}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Channel 5, literal timing pins
      tbl[5] = 12'hA5C;
      start(3'b101);
      repeat (520) tick();
      check("n521_ss_n", {31'd0, SS_n}, 32'd0);
      check("n521_cnv", {31'd0, cnv_cmplt}, 32'd0);
      tick();
      check("n522_ss_n", {31'd0, SS_n}, 32'd1);
      check("n522_cnv", {31'd0, cnv_cmplt}, 32'd1);
      check("n522_res", {20'd0, res}, 32'h0000_0A5C);
      check("ch5_addr", {29'd0, rx[13:11]}, 32'd5);
      frame_checks(3'b101);

      // Reset mid-frame at n=200
      tbl[4] = 12'($urandom_range(0, 4095));
      start(3'd4);
      repeat (199) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_ss_n", {31'd0, SS_n}, 32'd1);
      check("midrst_sclk", {31'd0, SCLK}, 32'd1);
      check("midrst_cnv", {31'd0, cnv_cmplt}, 32'd0);
      check("midrst_res", {20'd0, res}, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      exp_q.delete();
      tick();
      do_frame(3'd4, 1'b0);

      // Back-to-back: ch1 then ch7
      tbl[1] = 12'h001;
      tbl[7] = 12'hFFF;
      do_frame(3'd1, 1'b0);
      tick();
      tick();
      strt_cnv = 1'b1;
      chnnl    = 3'd7;
      check("b2b_cnv_before", {31'd0, cnv_cmplt}, 32'd1);
      tick();
      strt_cnv = 1'b0;
      check("b2b_cnv_drop", {31'd0, cnv_cmplt}, 32'd0);
      check("b2b_res_hold", {20'd0, res}, 32'h0000_0001);
      begin
         int n;
         wait_done(1'b0, n);
         check("b2b_done_cycle", n, 522);
      end
      check("b2b_res_fff", {20'd0, res}, 32'h0000_0FFF);
      frame_checks(3'd7);

      // Ignored starts at n=100 and n=521
      tbl[2] = 12'($urandom_range(0, 4095));
      start(3'd2);
      for (int n = 2; n <= 540; n++) begin
         tick();
         strt_cnv = (n == 99 || n == 520);
         chnnl    = (n == 99 || n == 520) ? 3'd6 : 3'd2;
      end
      strt_cnv = 1'b0;
      check("ign_cnv_stays", {31'd0, cnv_cmplt}, 32'd1);
      check("ign_one_frame", exp_q.size(), 1);
      frame_checks(3'd2);

      // Channel toggles after acceptance
      tbl[3] = 12'($urandom_range(0, 4095));
      do_frame(3'b011, 1'b1);
      check("tgl_addr", {29'd0, rx[13:11]}, 32'd3);

      // Sweep all channels with random values and random gaps
      for (int c = 0; c < 8; c++) begin
         tbl[c] = 12'($urandom_range(0, 4095));
         repeat ($urandom_range(0, 5)) tick();
         do_frame(3'(c), 1'b0);
      end

      tick();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule : tb_a2d_intf
